// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared PC width, opcode constants and sequencer FSM states
package pipeline_pkg;
  localparam int          PC_W             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_HALT      = 2'd3
  } seq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch sequencer control/status bundle between datapath and sequencer
interface pc_sequencer_if;
  import pipeline_pkg::*;

  logic              stall_i;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_addr;
  logic              resume_i;
  logic [5:0]        fetch_opcode;
  logic [PC_W-1:0]   pc_out;
  logic [PC_W-1:0]   pc_plus_step;
  logic              fetch_valid;
  logic              flush;
  logic              halted;
  logic              misalign;
  logic [31:0]       fetch_count;
  logic [1:0]        state_dbg;

  modport master (
    output stall_i, redirect_valid, redirect_addr, resume_i, fetch_opcode,
    input  pc_out, pc_plus_step, fetch_valid, flush, halted, misalign,
           fetch_count, state_dbg
  );

  modport slave (
    input  stall_i, redirect_valid, redirect_addr, resume_i, fetch_opcode,
    output pc_out, pc_plus_step, fetch_valid, flush, halted, misalign,
           fetch_count, state_dbg
  );
endinterface

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - 4-bit loadable down-counter with zero flag; saturates at zero
module cycle_down_counter #(
  parameter logic [3:0] RESET_VAL = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);
  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= RESET_VAL;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_dec && (r_count != 4'd0))
      r_count <= r_count - 4'd1;
  end

  assign o_zero = (r_count == 4'd0);
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer: boot delay, +step, stall, redirect, halt drain and resume
module pc_sequencer
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [5:0]  HALT_OPCODE  = OP_HALT
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);
  localparam logic [3:0]  BOOT_LOAD  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [31:0] STEP       = 32'(PC_STEP);

  seq_state_t  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_fetch_count, w_count_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic        w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic        w_fetch_valid, w_flush;
  logic [31:0] w_redirect_pc;
  logic        w_redirect_mis;

  assign w_redirect_pc  = {bus.redirect_addr[31:2], 2'b00};
  assign w_redirect_mis = (bus.redirect_addr[1:0] != 2'b00);

  cycle_down_counter #(.RESET_VAL(BOOT_LOAD)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (DRAIN_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_count_nxt    = r_fetch_count;
    w_misalign_nxt = r_misalign;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    w_fetch_valid  = (r_state == ST_RUN) && !bus.redirect_valid && !bus.stall_i;
    w_flush        = bus.redirect_valid && ((r_state == ST_RUN) || (r_state == ST_HALT_PEND));
    case (r_state)
      ST_BOOT: begin
        if (w_cnt_zero) w_state_nxt = ST_RUN;
        else            w_cnt_dec   = 1'b1;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          w_pc_nxt       = w_redirect_pc;
          w_misalign_nxt = r_misalign | w_redirect_mis;
        end else if (bus.stall_i) begin
          w_pc_nxt = r_pc;
        end else if (bus.fetch_opcode == HALT_OPCODE) begin
          // halt is not issued; wait for older branches to resolve first
          w_cnt_load  = 1'b1;
          w_state_nxt = ST_HALT_PEND;
        end else begin
          w_pc_nxt    = r_pc + STEP;
          w_count_nxt = r_fetch_count + 32'd1;
        end
      end
      ST_HALT_PEND: begin
        if (bus.redirect_valid) begin
          w_pc_nxt       = w_redirect_pc;
          w_misalign_nxt = r_misalign | w_redirect_mis;
          w_state_nxt    = ST_RUN;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_HALT: begin
        if (bus.resume_i) begin
          w_pc_nxt    = r_pc + STEP;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'd0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_count <= w_count_nxt;
      r_misalign    <= w_misalign_nxt;
    end
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_plus_step = r_pc + STEP;
  assign bus.fetch_valid  = w_fetch_valid;
  assign bus.flush        = w_flush;
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.misalign     = r_misalign;
  assign bus.fetch_count  = r_fetch_count;
  assign bus.state_dbg    = r_state;
endmodule
